// File: rtl/gifplayer_soc_pio_arbiter.sv
// Round-robin arbiter sharing one zero-wait-state Avalon-MM PIO slave
// between NUM_REQ requesters over a req/ack handshake.
module gifplayer_soc_pio_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_write_n,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           ack_readdata,
    output logic                        busy,
    output logic                        chipselect,
    output logic                        write_n,
    output logic [ADDR_W-1:0]           address,
    output logic [DATA_W-1:0]           writedata,
    input  logic [DATA_W-1:0]           readdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic               found;
    logic [IW-1:0]      gnt;
    logic               sel_wn;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // First pass looks above the pointer, second pass wraps to the bottom.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && i > int'(last_q)) begin
                found = 1'b1;
                gnt   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                gnt   = IW'(i);
            end
        end
    end

    always_comb begin
        sel_wn    = 1'b1;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == IW'(i)) begin
                sel_wn    = req_write_n[i];
                sel_addr  = req_address[i*ADDR_W +: ADDR_W];
                sel_wdata = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        cs_d    = cs_q;
        wn_d    = wn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                ack_d = '0;
                cs_d  = 1'b0;
                if (found) begin
                    idx_d   = gnt;
                    wn_d    = sel_wn;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    cs_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wn_q) rdata_d = readdata;
                cs_d         = 1'b0;
                wn_d         = 1'b1;
                ack_d        = '0;
                ack_d[idx_q] = 1'b1;
                last_d       = idx_q;
                state_d      = S_ACK;
            end
            S_ACK: begin
                ack_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                ack_d   = '0;
                cs_d    = 1'b0;
                wn_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            last_q  <= LAST_RST;
            idx_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ack          = ack_q;
    assign ack_readdata = rdata_q;
    assign busy         = (state_q != S_IDLE);
    assign chipselect   = cs_q;
    assign write_n      = wn_q;
    assign address      = addr_q;
    assign writedata    = wdata_q;

endmodule

// File: tb/tb_gifplayer_soc_pio_arbiter.sv
// Bench for the PIO arbiter: directed handshake cases plus random
// traffic checked against a transaction-level round-robin model.
module tb_gifplayer_soc_pio_arbiter;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    rq;
    logic [N-1:0]    rwn;
    logic [N*AW-1:0] ra;
    logic [N*DW-1:0] rd;
    logic [N-1:0]    ack;
    logic [DW-1:0]   ack_readdata;
    logic            busy;
    logic            chipselect;
    logic            write_n;
    logic [AW-1:0]   address;
    logic [DW-1:0]   writedata;
    logic [DW-1:0]   readdata;

    gifplayer_soc_pio_arbiter #(
        .NUM_REQ(N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .req          (rq),
        .req_write_n  (rwn),
        .req_address  (ra),
        .req_writedata(rd),
        .ack          (ack),
        .ack_readdata (ack_readdata),
        .busy         (busy),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave: registered write, combinational read
    logic [DW-1:0] mem_s [4];
    initial for (int i = 0; i < 4; i++) mem_s[i] = '0;
    always @(posedge clk)
        if (chipselect && !write_n) mem_s[address] <= writedata;
    assign readdata = mem_s[address];

    int            n_chk;
    int            n_fail;
    int            last_m;
    logic [DW-1:0] mem_m [4];
    logic [DW-1:0] rd_m;
    logic [N-1:0]  ack_log [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic wn,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq[i]            = 1'b1;
        rwn[i]           = wn;
        ra[i*AW +: AW]   = a;
        rd[i*DW +: DW]   = d;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
                $urandom());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rq    = '0;
        #2;
        rst_n  = 1'b1;
        last_m = N - 1;
        rd_m   = '0;
        step();
    endtask

    // One arbitration slot starting at an IDLE sample point.
    // mode 0: served requester drops, 1: keeps, 2: random.
    task automatic slot(input int mode);
        int            g;
        logic          e_wn;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        chk("idle_busy", {31'b0, busy}, 0);
        chk("idle_ack", {28'b0, ack}, 0);
        g = pick(rq, last_m);
        if (g < 0) begin
            step();
            chk("idle_cs", {31'b0, chipselect}, 0);
            return;
        end
        e_wn = rwn[g];
        e_a  = ra[g*AW +: AW];
        e_d  = rd[g*DW +: DW];
        step();
        chk("iss_cs", {31'b0, chipselect}, 1);
        chk("iss_wn", {31'b0, write_n}, {31'b0, e_wn});
        chk("iss_addr", {30'b0, address}, {30'b0, e_a});
        chk("iss_busy", {31'b0, busy}, 1);
        chk("iss_ack", {28'b0, ack}, 0);
        if (!e_wn) chk("iss_wdata", writedata, e_d);
        step();
        chk("ack_onehot", {28'b0, ack}, 32'(1 << g));
        chk("ack_busy", {31'b0, busy}, 1);
        chk("ack_cs", {31'b0, chipselect}, 0);
        chk("ack_wn", {31'b0, write_n}, 1);
        if (e_wn) rd_m = mem_m[e_a];
        else mem_m[e_a] = e_d;
        chk("ack_rdata", ack_readdata, rd_m);
        ack_log.push_back(ack);
        last_m = g;
        if (mode == 0) rq[g] = 1'b0;
        else if (mode == 2) begin
            if ($urandom_range(0, 1) == 1) rq[g] = 1'b0;
            else rand_req(g);
        end
        step();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 4; i++) mem_m[i] = '0;
        rst_n = 1'b0;
        rq    = '0;
        rwn   = '1;
        ra    = '0;
        rd    = '0;
        last_m = N - 1;
        rd_m   = '0;
        #12;
        chk("rst_ack", {28'b0, ack}, 0);
        chk("rst_rdata", ack_readdata, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_cs", {31'b0, chipselect}, 0);
        chk("rst_wn", {31'b0, write_n}, 1);
        chk("rst_addr", {30'b0, address}, 0);
        chk("rst_wdata", writedata, 0);
        rst_n = 1'b1;
        step();

        // single write then read-back
        set_req(0, 1'b0, 2'd0, 32'h0000_00A5);
        slot(0);
        chk("out_port", mem_s[0], 32'h0000_00A5);
        set_req(1, 1'b1, 2'd0, 32'h0);
        slot(0);
        chk("readback", ack_readdata, 32'h0000_00A5);

        // all four at once from reset
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, 1'b0, AW'(i), 32'h100 + 32'(i));
        ack_log.delete();
        for (int i = 0; i < N; i++) slot(0);
        for (int i = 0; i < N; i++) begin
            chk("all4_order", {28'b0, ack_log[i]}, 32'(1 << i));
            chk("all4_mem", mem_s[i], 32'h100 + 32'(i));
        end

        // contention between 1 and 3, both held
        do_reset();
        set_req(1, 1'b1, 2'd1, 32'h0);
        set_req(3, 1'b1, 2'd2, 32'h0);
        ack_log.delete();
        for (int i = 0; i < 4; i++) slot(1);
        for (int i = 0; i < 4; i++)
            chk("cont_order", {28'b0, ack_log[i]},
                (i % 2 == 0) ? 32'h2 : 32'h8);
        rq = '0;
        step();

        // reset during ISSUE of a write from requester 2
        do_reset();
        set_req(2, 1'b0, 2'd1, 32'hDEAD_BEEF);
        step();
        chk("rst_iss_cs", {31'b0, chipselect}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cs", {31'b0, chipselect}, 0);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        chk("rst_mid_wn", {31'b0, write_n}, 1);
        rq     = '0;
        last_m = N - 1;
        rd_m   = '0;
        step();
        chk("rst_mid_ack", {28'b0, ack}, 0);
        rst_n = 1'b1;
        step();
        chk("rst_post_ack", {28'b0, ack}, 0);
        chk("rst_no_write", mem_s[1], 32'h101);
        set_req(0, 1'b0, 2'd3, 32'h0000_1111);
        set_req(2, 1'b0, 2'd2, 32'h0000_2222);
        ack_log.delete();
        slot(0);
        slot(0);
        chk("rst_first0", {28'b0, ack_log[0]}, 32'h1);
        chk("rst_then2", {28'b0, ack_log[1]}, 32'h4);

        // requester drops req during ISSUE
        set_req(0, 1'b1, 2'd3, 32'h0);
        step();
        chk("drop_cs", {31'b0, chipselect}, 1);
        rq = '0;
        step();
        chk("drop_ack", {28'b0, ack}, 32'h1);
        chk("drop_rdata", ack_readdata, 32'h0000_1111);
        step();
        chk("drop_idle_busy", {31'b0, busy}, 0);
        chk("drop_idle_ack", {28'b0, ack}, 0);
        last_m = 0;
        rd_m   = 32'h0000_1111;

        // random traffic
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < N; i++)
                if (!rq[i] && $urandom_range(0, 2) == 0) rand_req(i);
            slot(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
